// File: rtl/fsqrt_issue_arbiter_if.sv
// fsqrt_issue_arbiter_if: requester, response, fsqrt-unit and status signals of the fsqrt issue arbiter
interface fsqrt_issue_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*NREQ-1:0] req_x, rsp_y;
  logic fsqrt_valid, fsqrt_out_valid, busy, err;
  logic [31:0] fsqrt_x, fsqrt_y;
  modport slave (
    input req_valid, req_x, rsp_ready, fsqrt_y, fsqrt_out_valid,
    output req_ready, rsp_valid, rsp_y, fsqrt_valid, fsqrt_x, busy, err
  );
  modport master (
    output req_valid, req_x, rsp_ready, fsqrt_y, fsqrt_out_valid,
    input req_ready, rsp_valid, rsp_y, fsqrt_valid, fsqrt_x, busy, err
  );
endinterface

// File: rtl/fsqrt_issue_arbiter.sv
// fsqrt_issue_arbiter: round-robin, credit-gated sharing of one pipelined fsqrt unit with per-requester response FIFOs
module fsqrt_issue_arbiter #(
  parameter int NREQ = 4,
  parameter int FSQRT_LAT = 3,
  parameter int RSP_DEPTH = 2
) (
  input logic sys_clk,
  input logic rst,
  fsqrt_issue_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = RSP_DEPTH > 1 ? $clog2(RSP_DEPTH) : 1;
  localparam int FW = $clog2(FSQRT_LAT + 2);
  logic [FW-1:0] flush_q, flush_d;
  logic [IW-1:0] ptr_q, ptr_d, gid, j, fid_q, tail_id;
  logic [NREQ-1:0] elig, gnt, pop, push, miss_v, rv;
  logic [32*NREQ-1:0] ry;
  logic found, fv_q, err_q, flushing, tail_v, push_any, miss, spur;
  logic [31:0] fx_q;
  logic [FSQRT_LAT-1:0] tv_q;
  logic [IW-1:0] tid_q [FSQRT_LAT];
  logic [CW-1:0] cnt_q [NREQ];
  logic [CW-1:0] occ_q [NREQ];
  logic [PW-1:0] rd_q [NREQ];
  logic [PW-1:0] wr_q [NREQ];
  logic [31:0] mem_q [NREQ][RSP_DEPTH];
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(RSP_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign flushing = flush_q != '0;
  // the issue register {fv_q,fid_q} is the tag's first stage; tv_q/tid_q then line the tail up with out_valid
  assign tail_v = tv_q[FSQRT_LAT-1];
  assign tail_id = tid_q[FSQRT_LAT-1];
  assign push_any = bus.fsqrt_out_valid & tail_v & !flushing;
  assign miss = tail_v & !bus.fsqrt_out_valid & !flushing;
  assign spur = bus.fsqrt_out_valid & !tail_v & !flushing;
  always_comb begin
    elig = '0;
    gnt = '0;
    gid = '0;
    j = '0;
    found = 1'b0;
    push = '0;
    miss_v = '0;
    pop = '0;
    rv = '0;
    ry = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus.req_valid[i] && cnt_q[i] < CW'(RSP_DEPTH) && !flushing;
      push[i] = push_any && tail_id == IW'(i);
      miss_v[i] = miss && tail_id == IW'(i);
      rv[i] = occ_q[i] != '0;
      pop[i] = bus.rsp_ready[i] && rv[i];
      ry[32*i +: 32] = rv[i] ? mem_q[i][rd_q[i]] : '0;
    end
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && elig[j]) begin
        found = 1'b1;
        gnt[j] = 1'b1;
        gid = j;
      end
    end
    ptr_d = !found ? ptr_q : gid == IW'(NREQ - 1) ? '0 : gid + 1'b1;
    flush_d = flushing ? flush_q - 1'b1 : flush_q;
  end
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      flush_q <= FW'(FSQRT_LAT + 1);
      ptr_q <= '0;
      fv_q <= 1'b0;
      fid_q <= '0;
      fx_q <= '0;
      err_q <= 1'b0;
      tv_q <= '0;
      for (int k = 0; k < FSQRT_LAT; k++) tid_q[k] <= '0;
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= '0;
        occ_q[i] <= '0;
        rd_q[i] <= '0;
        wr_q[i] <= '0;
      end
    end else begin
      flush_q <= flush_d;
      ptr_q <= ptr_d;
      fv_q <= found;
      fid_q <= gid;
      fx_q <= found ? bus.req_x[32*gid +: 32] : fx_q;
      err_q <= err_q | miss | spur;
      tv_q[0] <= fv_q;
      tid_q[0] <= fid_q;
      for (int k = 1; k < FSQRT_LAT; k++) begin
        tv_q[k] <= tv_q[k-1];
        tid_q[k] <= tid_q[k-1];
      end
      // a missing result returns its credit so the requester cannot lock up
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i] <= cnt_q[i] + CW'(gnt[i]) - CW'(pop[i]) - CW'(miss_v[i]);
        occ_q[i] <= occ_q[i] + CW'(push[i]) - CW'(pop[i]);
        wr_q[i] <= push[i] ? nxt(wr_q[i]) : wr_q[i];
        rd_q[i] <= pop[i] ? nxt(rd_q[i]) : rd_q[i];
      end
    end
  end
  always_ff @(posedge sys_clk)
    for (int i = 0; i < NREQ; i++)
      if (push[i]) mem_q[i][wr_q[i]] <= bus.fsqrt_y;
  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rv;
  assign bus.rsp_y = ry;
  assign bus.fsqrt_valid = fv_q;
  assign bus.fsqrt_x = fx_q;
  assign bus.err = err_q;
  assign bus.busy = fv_q | (|tv_q) | (|rv);
endmodule

// File: tb/tb_fsqrt_issue_arbiter.sv
// tb_fsqrt_issue_arbiter: directed bench with a 3-stage fsqrt stand-in and per-requester expected-result queues
module tb_fsqrt_issue_arbiter;
  localparam int N = 4;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  bit spur = 1'b0;
  int total = 0;
  int bad = 0;
  int acc [N] = '{default: 0};
  int eg, a0, a1, a2;
  logic [31:0] sb_e;
  logic [31:0] exp_q [N][$];
  bit pv [3];
  logic [31:0] py [3];
  fsqrt_issue_arbiter_if #(.NREQ(N)) bus ();
  fsqrt_issue_arbiter #(.NREQ(N), .FSQRT_LAT(3), .RSP_DEPTH(2)) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 sys_clk = ~sys_clk;
  // bit-trick square root: exact for 4.0 -> 2.0, deterministic for everything else
  function automatic logic [31:0] fs(input logic [31:0] x);
    return (x >> 1) + 32'h1fc00000;
  endfunction
  // fsqrt stand-in: never reset, so ops issued before a reset still emerge afterwards
  always @(posedge sys_clk) begin
    pv[0] <= bus.fsqrt_valid;
    py[0] <= fs(bus.fsqrt_x);
    pv[1] <= pv[0];
    py[1] <= py[0];
    pv[2] <= pv[1];
    py[2] <= py[1];
  end
  assign bus.fsqrt_out_valid = pv[2] | spur;
  assign bus.fsqrt_y = py[2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask
  always @(negedge sys_clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          acc[i]++;
          exp_q[i].push_back(fs(bus.req_x[32*i +: 32]));
        end
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          sb_e = exp_q[i].size() != 0 ? exp_q[i][0] : 32'hxxxxxxxx;
          total++;
          assert (exp_q[i].size() != 0 && bus.rsp_y[32*i +: 32] === sb_e) else begin
            bad++;
            $error("FAIL rsp%0d obs=%h exp=%h", i, bus.rsp_y[32*i +: 32], sb_e);
          end
          if (exp_q[i].size() != 0) void'(exp_q[i].pop_front());
        end
      end
    end
  end
  initial begin
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.rsp_ready = '1;
    #1 rst = 1'b0;
    @(negedge sys_clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_y", 32'(bus.rsp_y != '0), 0);
    chk("rst_fsqrt_valid", 32'(bus.fsqrt_valid), 0);
    chk("rst_fsqrt_x", bus.fsqrt_x, 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);
    // single op through flush and the full pipeline
    bus.req_valid = 4'b0001;
    bus.req_x[31:0] = 32'h40800000;
    @(posedge sys_clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      chk("flush_no_grant", 32'(bus.req_ready), 0);
    end
    @(negedge sys_clk);
    chk("first_grant", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = '0;
    chk("t1_fsqrt_valid", 32'(bus.fsqrt_valid), 1);
    chk("t1_fsqrt_x", bus.fsqrt_x, 32'h40800000);
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      chk("t1_latency_wait", 32'(bus.rsp_valid[0]), 0);
    end
    @(negedge sys_clk);
    chk("t1_rsp_valid", 32'(bus.rsp_valid[0]), 1);
    chk("t1_rsp_y", bus.rsp_y[31:0], 32'h40000000);
    // all requesting: after granting 0 the pointer sits at 1
    step();
    eg = 1;
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) bus.req_x[32*i +: 32] = $urandom;
    for (int c = 0; c < 12; c++) begin
      @(negedge sys_clk);
      chk("t2_grant", 32'(bus.req_ready), 32'(1) << eg);
      if (c > 0) chk("t2_fsqrt_valid", 32'(bus.fsqrt_valid), 1);
      eg = (eg + 1) % N;
      step();
      for (int i = 0; i < N; i++) bus.req_x[32*i +: 32] = $urandom;
    end
    bus.req_valid = '0;
    repeat (8) step();
    @(negedge sys_clk);
    chk("t2_busy_drained", 32'(bus.busy), 0);
    for (int i = 0; i < N; i++) chk("t2_sb_empty", exp_q[i].size(), 0);
    // credit limit on requester 1 while requester 0 keeps being served
    step();
    a0 = acc[0];
    a1 = acc[1];
    bus.rsp_ready = 4'b1101;
    bus.req_valid = 4'b0011;
    repeat (12) step();
    @(negedge sys_clk);
    chk("t3_blocked_ready", 32'(bus.req_ready[1]), 0);
    chk("t3_two_accepts", acc[1] - a1, 2);
    chk("t3_other_served", 32'(acc[0] - a0 >= 2), 1);
    step();
    bus.rsp_ready = 4'b1111;
    step();
    bus.rsp_ready = 4'b1101;
    a1 = acc[1];
    repeat (12) step();
    @(negedge sys_clk);
    chk("t3_one_more", acc[1] - a1, 1);
    chk("t3_blocked_again", 32'(bus.req_ready[1]), 0);
    chk("t3_rsp_held", 32'(bus.rsp_valid[1]), 1);
    step();
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    repeat (8) step();
    @(negedge sys_clk);
    chk("t3_busy_drained", 32'(bus.busy), 0);
    // requester 2 at full credit: pop of the head coincides with the second push
    step();
    a2 = acc[2];
    bus.rsp_ready = 4'b1011;
    bus.req_valid = 4'b0100;
    step();
    step();
    bus.req_valid = '0;
    chk("t4_two_accepts", acc[2] - a2, 2);
    repeat (3) step();
    bus.rsp_ready = '1;
    @(negedge sys_clk);
    chk("t4_head_ready", 32'(bus.rsp_valid[2]), 1);
    step();
    @(negedge sys_clk);
    chk("t4_still_one", 32'(bus.rsp_valid[2]), 1);
    step();
    @(negedge sys_clk);
    chk("t4_empty", 32'(bus.rsp_valid[2]), 0);
    chk("t4_sb_empty", exp_q[2].size(), 0);
    // spurious result, then reset mid-stream
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    @(negedge sys_clk);
    chk("t5_err_set", 32'(bus.err), 1);
    chk("t5_no_rsp", 32'(bus.rsp_valid), 0);
    repeat (3) step();
    @(negedge sys_clk);
    chk("t5_err_sticky", 32'(bus.err), 1);
    step();
    bus.req_valid = '1;
    repeat (6) step();
    rst = 1'b0;
    @(negedge sys_clk);
    chk("t5_rst_req_ready", 32'(bus.req_ready), 0);
    chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("t5_rst_rsp_y", 32'(bus.rsp_y != '0), 0);
    chk("t5_rst_fsqrt_valid", 32'(bus.fsqrt_valid), 0);
    chk("t5_rst_fsqrt_x", bus.fsqrt_x, 0);
    chk("t5_rst_busy", 32'(bus.busy), 0);
    chk("t5_rst_err", 32'(bus.err), 0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge sys_clk);
      chk("t5_flush_no_grant", 32'(bus.req_ready), 0);
    end
    @(negedge sys_clk);
    chk("t5_grant_after_flush", 32'(bus.req_ready), 1);
    chk("t5_err_after_flush", 32'(bus.err), 0);
    repeat (10) step();
    bus.req_valid = '0;
    repeat (8) step();
    @(negedge sys_clk);
    chk("t5_final_busy", 32'(bus.busy), 0);
    chk("t5_final_err", 32'(bus.err), 0);
    for (int i = 0; i < N; i++) chk("t5_sb_empty", exp_q[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
